sample_stream_source: RTL and testbench

Buffered signed-sample transmitter: the producing end of the sample stream that the running min/max tracker consumes. Software or a bench loads up to DEPTH signed words. On start, the block replays them in order with a valid/ready handshake, either once or looping. It lets the tracker be driven cycle-accurately, with backpressure, from a reusable sequence.

---
 rtl/sample_stream_source.sv | 71 +++++++
 tb/tb_sample_stream_source.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sample_stream_source.sv
// sample_stream_source: replays up to DEPTH loaded signed samples over valid/ready (once or looping); ports: wr_en/wr_data/clear load, start/loop control, ready/data_out/valid stream, busy/done/full/count status
module sample_stream_source #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              clear,
  input  logic              start,
  input  logic              loop,
  input  logic              ready,
  output logic [WIDTH-1:0]  data_out,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W:0]   count
);
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, rd_nxt, wa;
  logic hs, last, go, empty_start, idle_wr, we, finish;
  always_comb begin
    hs          = valid && ready;
    last        = ((ADDR_W+1)'(rd_ptr) + (ADDR_W+1)'(1)) == count;
    rd_nxt      = rd_ptr + ADDR_W'(1);
    full        = count == (ADDR_W+1)'(DEPTH);
    go          = state == IDLE && start && count != '0;
    empty_start = state == IDLE && start && count == '0;
    idle_wr     = state == IDLE && !start;
    we          = !reset && idle_wr && wr_en && (clear || !full);
    wa          = clear ? '0 : count[ADDR_W-1:0];
    finish      = state == PLAY && hs && last && !loop;
  end
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = go ? PLAY : finish ? DONE : state == DONE ? IDLE : state;
  always_comb
    busy = state != IDLE;
  always_ff @(posedge clock)
    if (we) mem[wa] <= wr_data;
  always_ff @(posedge clock)
    if (reset) begin
      data_out <= '0;
      valid    <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
    end else begin
      done <= empty_start || finish;
      if (go) begin
        rd_ptr   <= '0;
        data_out <= mem[0];
        valid    <= 1'b1;
      end else if (idle_wr && clear) begin
        count <= wr_en ? (ADDR_W+1)'(1) : '0;
      end else if (idle_wr && wr_en && !full) begin
        count <= count + (ADDR_W+1)'(1);
      end else if (state == PLAY && hs) begin
        rd_ptr   <= last ? '0 : rd_nxt;
        data_out <= last ? mem[0] : mem[rd_nxt];
        valid    <= !finish;
      end
    end
endmodule

// File: tb/tb_sample_stream_source.sv
// tb_sample_stream_source: directed-vector self-checking bench for sample_stream_source
module tb_sample_stream_source;
  logic clock = 1'b0;
  logic reset, wr_en, clear, start, loop, ready;
  logic [31:0] wr_data, data_out;
  logic valid, busy, done, full;
  logic [4:0] count;
  int n = 0;
  int errs = 0;
  int cyc;
  logic [31:0] eq[$];
  bit rq[$];
  sample_stream_source #(.WIDTH(32), .DEPTH(16), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .clear(clear), .start(start), .loop(loop), .ready(ready),
    .data_out(data_out), .valid(valid), .busy(busy), .done(done),
    .full(full), .count(count)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [31:0] v);
    wr_en = 1'b1;
    wr_data = v;
    step();
    wr_en = 1'b0;
  endtask
  task automatic clr();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask
  task automatic play(input int drop_at, output int cycles);
    int k;
    bit fin;
    k = 0;
    fin = 0;
    cycles = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("latency_valid", {31'b0, valid}, 32'd1);
    while (!fin && cycles < 200) begin
      ready = rq[cycles % rq.size()];
      if (k == drop_at) loop = 1'b0;
      if (valid && ready) begin
        if (k < eq.size()) chk($sformatf("data%0d", k), data_out, eq[k]);
        else chk("extra_beat", k, eq.size());
        k++;
      end
      step();
      cycles++;
      if (done) begin
        fin = 1;
        chk("beats_at_done", k, eq.size());
        chk("busy_at_done", {31'b0, busy}, 32'd1);
        chk("valid_at_done", {31'b0, valid}, 32'd0);
      end
    end
    if (!fin) chk("done_timeout", 32'd0, 32'd1);
    ready = 1'b0;
    step();
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("busy_after", {31'b0, busy}, 32'd0);
  endtask
  initial begin
    reset = 1'b1; wr_en = 0; clear = 0; start = 0; loop = 0; ready = 0; wr_data = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_count", {27'b0, count}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    wr(32'd2); wr(32'd3); wr(32'hFFFF_FFF8); wr(32'd56);
    chk("count4", {27'b0, count}, 32'd4);
    eq = {32'd2, 32'd3, 32'hFFFF_FFF8, 32'd56};
    rq = {1'b1};
    play(-1, cyc);
    chk("b2b_cycles", cyc, 32'd4);
    chk("count_kept", {27'b0, count}, 32'd4);
    rq = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    play(-1, cyc);
    chk("bp_cycles", cyc, 32'd7);
    clr();
    wr(32'd125); wr(32'hFFFF_FF83); wr(32'd200);
    eq = {32'd125, 32'hFFFF_FF83, 32'd200, 32'd125, 32'hFFFF_FF83, 32'd200,
          32'd125, 32'hFFFF_FF83, 32'd200};
    rq = {1'b1};
    loop = 1'b1;
    play(7, cyc);
    chk("loop_cycles", cyc, 32'd9);
    clr();
    for (int i = 0; i < 17; i++) begin
      wr(i);
      if (i == 14) chk("not_full15", {31'b0, full}, 32'd0);
      if (i == 15) chk("full16", {31'b0, full}, 32'd1);
    end
    chk("count_sat", {27'b0, count}, 32'd16);
    eq = {};
    for (int i = 0; i < 16; i++) eq.push_back(i);
    play(-1, cyc);
    clr();
    chk("cleared", {27'b0, count}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("empty_done", {31'b0, done}, 32'd1);
    chk("empty_valid", {31'b0, valid}, 32'd0);
    chk("empty_busy", {31'b0, busy}, 32'd0);
    step();
    chk("empty_done_end", {31'b0, done}, 32'd0);
    chk("empty_valid2", {31'b0, valid}, 32'd0);
    wr(32'd9);
    clear = 1'b1;
    wr(32'hFFFF_FFF4);
    clear = 1'b0;
    chk("clr_wr_count", {27'b0, count}, 32'd1);
    eq = {32'hFFFF_FFF4};
    play(-1, cyc);
    clr();
    wr(32'd2); wr(32'd3); wr(32'hFFFF_FFF8); wr(32'd56);
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mid_d0", data_out, 32'd2);
    step();
    chk("mid_d1", data_out, 32'd3);
    step();
    chk("mid_d2", data_out, 32'hFFFF_FFF8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    ready = 1'b0;
    chk("mid_rst_valid", {31'b0, valid}, 32'd0);
    chk("mid_rst_count", {27'b0, count}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    step();
    chk("mid_rst_nodone", {31'b0, done}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_rst_done", {31'b0, done}, 32'd1);
    chk("post_rst_valid", {31'b0, valid}, 32'd0);
    step();
    chk("post_rst_done_end", {31'b0, done}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
